// File: rtl/param_dual_port_ram_if.sv
// Request/response bundle for param_dual_port_ram: clear control, RW port 0, RO port 1.
// PARITY_CHECK_EN adds the parity error flags and the port 0 parity inject input.
interface param_dual_port_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  clear_req;
  logic                  busy;
  logic                  p0_en;
  logic                  p0_wr_en;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic [DATA_WIDTH-1:0] p0_rdata;
  logic                  p0_rvalid;
  logic                  p1_en;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_rdata;
  logic                  p1_rvalid;
  logic                  collision;
`ifdef PARITY_CHECK_EN
  logic                  p0_perr_inject;
  logic                  p0_perr;
  logic                  p1_perr;

  modport master (
    output clear_req, p0_en, p0_wr_en, p0_addr, p0_wdata, p1_en, p1_addr, p0_perr_inject,
    input  busy, p0_rdata, p0_rvalid, p1_rdata, p1_rvalid, collision, p0_perr, p1_perr
  );
  modport slave (
    input  clear_req, p0_en, p0_wr_en, p0_addr, p0_wdata, p1_en, p1_addr, p0_perr_inject,
    output busy, p0_rdata, p0_rvalid, p1_rdata, p1_rvalid, collision, p0_perr, p1_perr
  );
`else
  modport master (
    output clear_req, p0_en, p0_wr_en, p0_addr, p0_wdata, p1_en, p1_addr,
    input  busy, p0_rdata, p0_rvalid, p1_rdata, p1_rvalid, collision
  );
  modport slave (
    input  clear_req, p0_en, p0_wr_en, p0_addr, p0_wdata, p1_en, p1_addr,
    output busy, p0_rdata, p0_rvalid, p1_rdata, p1_rvalid, collision
  );
`endif
endinterface

// File: rtl/param_dual_port_ram.sv
// Simple dual-port RAM (port 0 RW, port 1 RO) with registered reads and a clear sweeper.
// Optional even-parity storage and checking is enabled by defining PARITY_CHECK_EN.
module param_dual_port_ram #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter bit WRITE_FIRST = 1'b1
) (
  input logic                  clock,
  input logic                  reset_n,
  param_dual_port_ram_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;
`ifdef PARITY_CHECK_EN
  localparam int MEM_W = DATA_WIDTH + 1;
`else
  localparam int MEM_W = DATA_WIDTH;
`endif

  typedef enum logic {S_CLEAR, S_IDLE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
  logic                  p0_rvalid_q, p0_rvalid_d;
  logic                  p1_rvalid_q, p1_rvalid_d;
  logic                  collision_q, collision_d;
`ifdef PARITY_CHECK_EN
  logic                  p0_perr_q, p0_perr_d;
  logic                  p1_perr_q, p1_perr_d;
`endif

  logic [MEM_W-1:0]      mem [DEPTH];
  logic                  idle, p0_wr, p0_rd, p1_rd, hit;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [MEM_W-1:0]      new_word, wr_word, p0_word, p1_word;

`ifdef PARITY_CHECK_EN
  // Even parity: stored word has an even number of ones unless inject flips it.
  assign new_word = {(^bus.p0_wdata) ^ bus.p0_perr_inject, bus.p0_wdata};
`else
  assign new_word = bus.p0_wdata;
`endif

  always_comb begin
    idle    = (state_q == S_IDLE);
    p0_wr   = idle & bus.p0_en & bus.p0_wr_en;
    p0_rd   = idle & bus.p0_en & ~bus.p0_wr_en;
    p1_rd   = idle & bus.p1_en;
    hit     = p0_wr & p1_rd & (bus.p0_addr == bus.p1_addr);
    // The sweeper owns the write port while clearing; ports are locked out.
    wr_en   = p0_wr | ~idle;
    wr_addr = idle ? bus.p0_addr : cnt_q;
    wr_word = idle ? new_word : '0;
    p0_word = mem[bus.p0_addr];
    p1_word = (hit && WRITE_FIRST) ? new_word : mem[bus.p1_addr];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    p0_rdata_d  = p0_rd ? p0_word[DATA_WIDTH-1:0] : p0_rdata_q;
    p1_rdata_d  = p1_rd ? p1_word[DATA_WIDTH-1:0] : p1_rdata_q;
    p0_rvalid_d = p0_rd;
    p1_rvalid_d = p1_rd;
    collision_d = hit;
`ifdef PARITY_CHECK_EN
    p0_perr_d   = p0_rd & (^p0_word);
    p1_perr_d   = p1_rd & (^p1_word);
`endif
    if (!idle) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    end else if (bus.clear_req) begin
      state_d = S_CLEAR;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_CLEAR;
      cnt_q       <= '0;
      busy_q      <= 1'b1;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      collision_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      p0_perr_q   <= 1'b0;
      p1_perr_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
      collision_q <= collision_d;
`ifdef PARITY_CHECK_EN
      p0_perr_q   <= p0_perr_d;
      p1_perr_q   <= p1_perr_d;
`endif
    end
  end

  // Array has no reset; contents are defined only after the clear sweep.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  assign bus.busy      = busy_q;
  assign bus.p0_rdata  = p0_rdata_q;
  assign bus.p1_rdata  = p1_rdata_q;
  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.collision = collision_q;
`ifdef PARITY_CHECK_EN
  assign bus.p0_perr   = p0_perr_q;
  assign bus.p1_perr   = p1_perr_q;
`endif

endmodule

// File: tb/tb_param_dual_port_ram.sv
// Scoreboard bench: two RAMs (write-first and read-first) share one stimulus stream.
module tb_param_dual_port_ram;
  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_errs   = 0;

  param_dual_port_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_a ();
  param_dual_port_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus_b ();

  param_dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WRITE_FIRST(1'b1)) dut_wf (
    .clock(clock), .reset_n(reset_n), .bus(bus_a));
  param_dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WRITE_FIRST(1'b0)) dut_rf (
    .clock(clock), .reset_n(reset_n), .bus(bus_b));

  assign bus_b.clear_req = bus_a.clear_req;
  assign bus_b.p0_en     = bus_a.p0_en;
  assign bus_b.p0_wr_en  = bus_a.p0_wr_en;
  assign bus_b.p0_addr   = bus_a.p0_addr;
  assign bus_b.p0_wdata  = bus_a.p0_wdata;
  assign bus_b.p1_en     = bus_a.p1_en;
  assign bus_b.p1_addr   = bus_a.p1_addr;
`ifdef PARITY_CHECK_EN
  assign bus_b.p0_perr_inject = bus_a.p0_perr_inject;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       busy;
    logic       p0v;
    logic [7:0] p0d;
    logic       p1v;
    logic [7:0] p1da;
    logic [7:0] p1db;
    logic       col;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mm [16];
  bit         m_busy;
  int         m_cnt;
  logic [7:0] m_p0d, m_p1da, m_p1db;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mm[i] = 8'h00;
    m_busy = 1'b0;
    m_cnt  = 0;
    m_p0d  = 8'h00;
    m_p1da = 8'h00;
    m_p1db = 8'h00;
  endtask

  task automatic cyc(input bit p0en, input bit p0wr, input logic [3:0] a0, input logic [7:0] wd,
                     input bit p1en, input logic [3:0] a1, input bit clr);
    exp_t e;
    bit   coll;
    bus_a.p0_en = p0en; bus_a.p0_wr_en = p0wr; bus_a.p0_addr = a0; bus_a.p0_wdata = wd;
    bus_a.p1_en = p1en; bus_a.p1_addr = a1; bus_a.clear_req = clr;
    e.p0v = 1'b0; e.p1v = 1'b0; e.col = 1'b0;
    if (!m_busy) begin
      coll = p0en && p0wr && p1en && (a0 == a1);
      if (p0en && !p0wr) begin e.p0v = 1'b1; m_p0d = mm[a0]; end
      if (p1en) begin
        e.p1v  = 1'b1;
        e.col  = coll;
        m_p1db = mm[a1];
        m_p1da = coll ? wd : mm[a1];
      end
      if (p0en && p0wr) mm[a0] = wd;
      if (clr) begin m_busy = 1'b1; m_cnt = 0; end
    end else begin
      mm[m_cnt] = 8'h00;
      if (m_cnt == 15) m_busy = 1'b0;
      else m_cnt++;
    end
    e.busy = m_busy; e.p0d = m_p0d; e.p1da = m_p1da; e.p1db = m_p1db;
    sb_q.push_back(e);
    @(posedge clock); #1;
    e = sb_q.pop_front();
    chk("busy",         bus_a.busy,      e.busy);
    chk("p0_rvalid",    bus_a.p0_rvalid, e.p0v);
    chk("p0_rdata",     bus_a.p0_rdata,  e.p0d);
    chk("p1_rvalid",    bus_a.p1_rvalid, e.p1v);
    chk("p1_rdata_wf",  bus_a.p1_rdata,  e.p1da);
    chk("collision_wf", bus_a.collision, e.col);
    chk("p1_rdata_rf",  bus_b.p1_rdata,  e.p1db);
    chk("collision_rf", bus_b.collision, e.col);
  endtask

  task automatic idle_inputs();
    bus_a.clear_req = 1'b0; bus_a.p0_en = 1'b0; bus_a.p0_wr_en = 1'b0; bus_a.p0_addr = '0;
    bus_a.p0_wdata = '0; bus_a.p1_en = 1'b0; bus_a.p1_addr = '0;
  endtask

  // Counts clock edges until busy drops; bounded so a stuck sweep still ends.
  task automatic wait_clear(output int n);
    n = 0;
    while (bus_a.busy && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},   bus_a.busy,      1'b1);
    chk({tag, "_p0d"},    bus_a.p0_rdata,  8'h00);
    chk({tag, "_p1d"},    bus_a.p1_rdata,  8'h00);
    chk({tag, "_p0v"},    bus_a.p0_rvalid, 1'b0);
    chk({tag, "_p1v"},    bus_a.p1_rvalid, 1'b0);
    chk({tag, "_col"},    bus_a.collision, 1'b0);
    chk({tag, "_p1d_rf"}, bus_b.p1_rdata,  8'h00);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    idle_inputs();
`ifdef PARITY_CHECK_EN
    bus_a.p0_perr_inject = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    chk_reset_vals("rst");
`ifdef PARITY_CHECK_EN
    chk("rst_p0perr", bus_a.p0_perr, 1'b0);
    chk("rst_p1perr", bus_a.p1_perr, 1'b0);
`endif
    @(negedge clock) reset_n = 1'b1;
    wait_clear(n);
    chk("init_busy_cycles", n, 16);
    model_reset();

    for (int i = 0; i < 16; i++) cyc(1, 0, 4'(i), 8'h00, 1, 4'(15 - i), 0);

    cyc(1, 1, 4'd3, 8'hA5, 0, 4'd0, 0);
    cyc(1, 0, 4'd3, 8'h00, 1, 4'd3, 0);

    cyc(1, 1, 4'd7, 8'h11, 0, 4'd0, 0);
    cyc(1, 1, 4'd7, 8'h22, 1, 4'd7, 0);
    chk("coll_wf_data", bus_a.p1_rdata, 8'h22);
    chk("coll_rf_data", bus_b.p1_rdata, 8'h11);
    cyc(1, 0, 4'd7, 8'h00, 1, 4'd7, 0);
    chk("after_coll_p1", bus_a.p1_rdata, 8'h22);

    for (int i = 0; i < 40; i++)
      cyc(1'($urandom), 1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom),
          1'($urandom), 4'($urandom_range(0, 3)), 0);

    for (int i = 0; i < 16; i++) cyc(1, 1, 4'(i), {4'(i), ~4'(i)}, 0, 4'd0, 0);
    cyc(0, 0, 4'd0, 8'h00, 1, 4'd4, 1);
    n = 0;
    while (bus_a.busy && n < 40) begin
      n++;
      cyc(1, n[0], 4'(n), 8'hEE, 1, 4'(n), n == 6);
    end
    chk("clear_busy_cycles", n, 16);
    for (int i = 0; i < 16; i++) cyc(1, 0, 4'(i), 8'h00, 1, 4'(i), 0);

    cyc(1, 1, 4'd2, 8'h5A, 0, 4'd0, 0);
    cyc(1, 0, 4'd2, 8'h00, 1, 4'd2, 0);
    cyc(0, 0, 4'd0, 8'h00, 0, 4'd0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 4'd0, 8'h00, 0, 4'd0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    idle_inputs();
    @(negedge clock) reset_n = 1'b1;
    wait_clear(n);
    chk("midrst_busy_cycles", n, 16);
    model_reset();
    cyc(1, 0, 4'd2, 8'h00, 1, 4'd2, 0);

`ifdef PARITY_CHECK_EN
    bus_a.p0_perr_inject = 1'b1;
    cyc(1, 1, 4'd9, 8'h3C, 0, 4'd0, 0);
    bus_a.p0_perr_inject = 1'b0;
    cyc(1, 0, 4'd9, 8'h00, 1, 4'd9, 0);
    chk("perr_inj_p0", bus_a.p0_perr, 1'b1);
    chk("perr_inj_p1", bus_a.p1_perr, 1'b1);
    cyc(1, 1, 4'd10, 8'h3C, 0, 4'd0, 0);
    cyc(1, 0, 4'd10, 8'h00, 1, 4'd10, 0);
    chk("perr_ok_p0", bus_a.p0_perr, 1'b0);
    chk("perr_ok_p1", bus_a.p1_perr, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
